// File: rtl/lcd_pkg.sv
// Shared state encoding, default delays and panel geometry for the LVDS panel
// power sequencer and the timing generator.
package lcd_pkg;

    typedef enum logic [2:0] {
        StOff        = 3'd0,
        StVddWait    = 3'd1,
        StVidWait    = 3'd2,
        StBlSync     = 3'd3,
        StRun        = 3'd4,
        StBlOffWait  = 3'd5,
        StVidOffWait = 3'd6,
        StCooldown   = 3'd7
    } lcd_state_e;

    localparam int unsigned TickDivDefault     = 72000;
    localparam int unsigned TVddVidDefault     = 20;
    localparam int unsigned TVidBlDefault      = 200;
    localparam int unsigned TBlVidDefault      = 200;
    localparam int unsigned TVidVddDefault     = 20;
    localparam int unsigned TOffMinDefault     = 500;
    localparam int unsigned PwmBitsDefault     = 8;
    localparam int unsigned PwmPrescaleDefault = 16;

    localparam int unsigned HActive = 1366;
    localparam int unsigned VActive = 768;
    localparam int unsigned HBlank  = 169;
    localparam int unsigned VBlank  = 12;
    localparam int unsigned HTotal  = HActive + HBlank;
    localparam int unsigned VTotal  = VActive + VBlank;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic vdd_on(input lcd_state_e s);
        return (s != StOff) && (s != StCooldown);
    endfunction

    function automatic logic video_on(input lcd_state_e s);
        return (s == StVidWait) || (s == StBlSync) || (s == StRun) || (s == StBlOffWait);
    endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: free-running prescaled counter, brightness latched at wrap and at
// RUN entry so a duty change never splits a period.
module lcd_bl_pwm #(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PWM_PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led_en_next,
    input  logic                run_entry,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                led_pwm
);

    localparam int unsigned PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PW-1:0] PreLast = PW'(PWM_PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CntMax = '1;

    logic [PW-1:0]       pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] lat_q, lat_d;
    logic                step;

    always_comb begin
        step  = (pre_q == PreLast);
        pre_d = step ? '0 : pre_q + 1'b1;
        cnt_d = step ? cnt_q + 1'b1 : cnt_q;
        lat_d = lat_q;
        if ((step && (cnt_q == CntMax)) || run_entry) begin
            lat_d = brightness;
        end
    end

    // Output is registered from next-state values so it lines up with led_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            led_pwm <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            led_pwm <= led_en_next & ((lat_d == CntMax) | (cnt_d < lat_d));
        end
    end

endmodule

// File: rtl/lcd_power_sequencer.sv
// LVDS panel power sequencer: VDD -> video -> backlight on the way up, reverse on
// the way down, with a sticky clock-loss fault and a minimum off time.
module lcd_power_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned TICK_DIV     = TickDivDefault,
    parameter int unsigned T_VDD_VID    = TVddVidDefault,
    parameter int unsigned T_VID_BL     = TVidBlDefault,
    parameter int unsigned T_BL_VID     = TBlVidDefault,
    parameter int unsigned T_VID_VDD    = TVidVddDefault,
    parameter int unsigned T_OFF_MIN    = TOffMinDefault,
    parameter int unsigned PWM_BITS     = PwmBitsDefault,
    parameter int unsigned PWM_PRESCALE = PwmPrescaleDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pll_locked,
    input  logic                frame_start,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                panel_vdd_en,
    output logic                video_en,
    output logic                led_en,
    output logic                led_pwm,
    output logic                ready,
    output logic                fault,
    output logic [2:0]          state
);

    localparam int unsigned TMax = max2(max2(max2(T_VDD_VID, T_VID_BL), max2(T_BL_VID,
                                       T_VID_VDD)), T_OFF_MIN);
    localparam int unsigned DW = (TMax > 0) ? $clog2(TMax + 1) : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);

    localparam logic [DW-1:0] LdVddVid = DW'(T_VDD_VID);
    localparam logic [DW-1:0] LdVidBl  = DW'(T_VID_BL);
    localparam logic [DW-1:0] LdBlVid  = DW'(T_BL_VID);
    localparam logic [DW-1:0] LdVidVdd = DW'(T_VID_VDD);
    localparam logic [DW-1:0] LdOffMin = DW'(T_OFF_MIN);

    lcd_state_e    state_q, state_d;
    logic [TW-1:0] tick_q;
    logic [DW-1:0] left_q;
    logic [DW-1:0] load_val;
    logic          load;
    logic          expired;
    logic          abort;
    logic          fault_d;
    logic          run_entry;

    always_comb begin
        // Last tick's final cycle, or a zero-length delay that expires on entry.
        expired  = (left_q == '0) || ((left_q == DW'(1)) && (tick_q == TickLast));
        abort    = ~enable | ~pll_locked;
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;

        unique case (state_q)
            StOff: begin
                if (enable && pll_locked && !fault) begin
                    state_d  = StVddWait;
                    load     = 1'b1;
                    load_val = LdVddVid;
                end
            end
            StVddWait: begin
                if (abort) begin
                    state_d  = StVidOffWait;
                    load     = 1'b1;
                    load_val = LdVidVdd;
                end else if (expired) begin
                    state_d  = StVidWait;
                    load     = 1'b1;
                    load_val = LdVidBl;
                end
            end
            StVidWait: begin
                if (abort) begin
                    state_d  = StVidOffWait;
                    load     = 1'b1;
                    load_val = LdVidVdd;
                end else if (expired) begin
                    state_d = StBlSync;
                end
            end
            StBlSync: begin
                if (abort) begin
                    state_d  = StVidOffWait;
                    load     = 1'b1;
                    load_val = LdVidVdd;
                end else if (frame_start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d  = StBlOffWait;
                    load     = 1'b1;
                    load_val = LdBlVid;
                end
            end
            StBlOffWait: begin
                if (expired) begin
                    state_d  = StVidOffWait;
                    load     = 1'b1;
                    load_val = LdVidVdd;
                end
            end
            StVidOffWait: begin
                if (expired) begin
                    state_d  = StCooldown;
                    load     = 1'b1;
                    load_val = LdOffMin;
                end
            end
            StCooldown: begin
                if (expired) begin
                    state_d = StOff;
                end
            end
            default: state_d = StOff;
        endcase

        fault_d = fault;
        if (!pll_locked && (state_q != StOff) && (state_q != StCooldown)) begin
            fault_d = 1'b1;
        end else if ((state_q == StOff) && !enable) begin
            fault_d = 1'b0;
        end

        run_entry = (state_d == StRun) && (state_q != StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StOff;
            tick_q       <= '0;
            left_q       <= '0;
            fault        <= 1'b0;
            panel_vdd_en <= 1'b0;
            video_en     <= 1'b0;
            led_en       <= 1'b0;
            ready        <= 1'b0;
        end else begin
            state_q <= state_d;
            fault   <= fault_d;
            if (load) begin
                tick_q <= '0;
                left_q <= load_val;
            end else if (!expired) begin
                if (tick_q == TickLast) begin
                    tick_q <= '0;
                    left_q <= left_q - 1'b1;
                end else begin
                    tick_q <= tick_q + 1'b1;
                end
            end
            panel_vdd_en <= vdd_on(state_d);
            video_en     <= video_on(state_d);
            led_en       <= (state_d == StRun);
            ready        <= (state_d == StRun);
        end
    end

    assign state = state_q;

    lcd_bl_pwm #(
        .PWM_BITS    (PWM_BITS),
        .PWM_PRESCALE(PWM_PRESCALE)
    ) u_bl_pwm (
        .clk        (clk),
        .rst        (rst),
        .led_en_next(state_d == StRun),
        .run_entry  (run_entry),
        .brightness (brightness),
        .led_pwm    (led_pwm)
    );

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Bench for lcd_power_sequencer: directed sequencing checks plus random stimulus
// compared every cycle against a deadline-based behavioural model.
module tb_lcd_power_sequencer;

    localparam int TD = 10;
    localparam int PS = 1;
    localparam int T_VDD_VID = 2;
    localparam int T_VID_BL  = 3;
    localparam int T_BL_VID  = 2;
    localparam int T_VID_VDD = 1;
    localparam int T_OFF_MIN = 4;

    logic       clk = 1'b0;
    logic       rst, enable, pll_locked, frame_start;
    logic [7:0] brightness;
    logic       panel_vdd_en, video_en, led_en, led_pwm, ready, fault;
    logic [2:0] state;

    lcd_power_sequencer #(
        .TICK_DIV    (TD),
        .T_VDD_VID   (T_VDD_VID),
        .T_VID_BL    (T_VID_BL),
        .T_BL_VID    (T_BL_VID),
        .T_VID_VDD   (T_VID_VDD),
        .T_OFF_MIN   (T_OFF_MIN),
        .PWM_BITS    (8),
        .PWM_PRESCALE(PS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pll_locked  (pll_locked),
        .frame_start (frame_start),
        .brightness  (brightness),
        .panel_vdd_en(panel_vdd_en),
        .video_en    (video_en),
        .led_en      (led_en),
        .led_pwm     (led_pwm),
        .ready       (ready),
        .fault       (fault),
        .state       (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;

    task automatic report(input string name, input int act, input int exp);
        n_fail++;
        if (n_fail <= 50) $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) report(name, int'(act), int'(exp));
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) report(name, int'(act), int'(exp));
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) report(name, act, exp);
    endtask

    // Model: state as the spec's integer code, timed delays as absolute deadlines.
    bit m_valid = 0;
    int m_st = 0, m_dl = -1, m_n = 0, m_lat = 0, m_cnt = 0;
    bit m_fault = 0;

    function automatic int dly(input int t);
        return (t == 0) ? 1 : t * TD;
    endfunction

    task automatic model_step();
        bit abort, exp_now, nf;
        int ns, nt;
        if (rst) begin
            m_valid = 1; m_st = 0; m_fault = 0; m_n = 0; m_lat = 0; m_dl = -1;
        end else if (m_valid) begin
            abort   = !enable || !pll_locked;
            exp_now = (cyc == m_dl);
            nf = m_fault;
            if (!pll_locked && m_st != 0 && m_st != 7) nf = 1;
            else if (m_st == 0 && !enable) nf = 0;
            ns = m_st;
            nt = -1;
            case (m_st)
                0: if (enable && pll_locked && !m_fault) begin ns = 1; nt = T_VDD_VID; end
                1: if (abort) begin ns = 6; nt = T_VID_VDD; end
                   else if (exp_now) begin ns = 2; nt = T_VID_BL; end
                2: if (abort) begin ns = 6; nt = T_VID_VDD; end
                   else if (exp_now) ns = 3;
                3: if (abort) begin ns = 6; nt = T_VID_VDD; end
                   else if (frame_start) ns = 4;
                4: if (abort) begin ns = 5; nt = T_BL_VID; end
                5: if (exp_now) begin ns = 6; nt = T_VID_VDD; end
                6: if (exp_now) begin ns = 7; nt = T_OFF_MIN; end
                default: if (exp_now) ns = 0;
            endcase
            m_n++;
            if (m_n % (256 * PS) == 0) m_lat = int'(brightness);
            if (ns == 4 && m_st != 4) m_lat = int'(brightness);
            if (nt >= 0) m_dl = cyc + dly(nt);
            m_st = ns;
            m_fault = nf;
        end
        m_cnt = (m_n / PS) % 256;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            if (m_valid) begin
                chk3("state", state, 3'(m_st));
                chk1("panel_vdd_en", panel_vdd_en, m_st >= 1 && m_st <= 6);
                chk1("video_en", video_en, m_st >= 2 && m_st <= 5);
                chk1("led_en", led_en, m_st == 4);
                chk1("ready", ready, m_st == 4);
                chk1("fault", fault, m_fault);
                chk1("led_pwm", led_pwm, m_st == 4 && (m_lat == 255 || m_cnt < m_lat));
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < base + c) @(negedge clk);
    endtask

    // Align to the next PWM period, latch start_br at the wrap, count highs over it.
    task automatic pwm_window(input logic [7:0] start_br, input bit mid, output int hits);
        while (m_cnt != 255) @(negedge clk);
        brightness = start_br;
        hits = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led_pwm === 1'b1) hits++;
            if (mid && i == 100) brightness = 8'hff;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        rst = 1; enable = 0; pll_locked = 1; frame_start = 0; brightness = 8'd0;
        repeat (3) @(negedge clk);
        chk3("rst_state", state, 3'd0);
        chk1("rst_vdd", panel_vdd_en, 1'b0);
        chk1("rst_video", video_en, 1'b0);
        chk1("rst_led", led_en, 1'b0);
        chk1("rst_pwm", led_pwm, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        rst = 0;
        repeat (3) @(negedge clk);

        // Power-up
        base = cyc; enable = 1;
        goto(1);  chk1("pu_vdd1", panel_vdd_en, 1'b1); chk1("pu_vid1", video_en, 1'b0);
        goto(20); chk1("pu_vid20", video_en, 1'b0);
        goto(21); chk1("pu_vid21", video_en, 1'b1);
        goto(50); chk3("pu_st50", state, 3'd2);
        goto(51); chk3("pu_st51", state, 3'd3);
        goto(60); frame_start = 1;
        goto(61); frame_start = 0;
        chk1("pu_led61", led_en, 1'b1); chk1("pu_ready61", ready, 1'b1);

        // PWM duty and mid-period change
        pwm_window(8'd0, 0, hits);   chki("pwm_duty0", hits, 0);
        pwm_window(8'd64, 1, hits);  chki("pwm_duty64_mid", hits, 64);
        pwm_window(8'd255, 0, hits); chki("pwm_duty255", hits, 256);

        // Power-down from RUN, enable re-asserted during cooldown
        base = cyc; enable = 0;
        goto(1);  chk1("pd_led1", led_en, 1'b0); chk3("pd_st1", state, 3'd5);
        goto(20); chk1("pd_vid20", video_en, 1'b1);
        goto(21); chk1("pd_vid21", video_en, 1'b0);
        goto(30); chk1("pd_vdd30", panel_vdd_en, 1'b1);
        goto(31); chk1("pd_vdd31", panel_vdd_en, 1'b0);
        goto(40); enable = 1;
        goto(70); chk3("pd_st70", state, 3'd7);
        goto(71); chk3("pd_st71", state, 3'd0);
        goto(72); chk3("pd_st72", state, 3'd1);

        // Abort in VID_WAIT (VDD_WAIT was entered at base+1)
        base = base + 71;
        goto(21); chk1("ab_vid21", video_en, 1'b1);
        goto(30); enable = 0; chk3("ab_st30", state, 3'd2);
        goto(31); chk1("ab_vid31", video_en, 1'b0); chk1("ab_led31", led_en, 1'b0);
        goto(40); chk1("ab_vdd40", panel_vdd_en, 1'b1);
        goto(41); chk1("ab_vdd41", panel_vdd_en, 1'b0); chk1("ab_led41", led_en, 1'b0);
        goto(81); chk3("ab_st81", state, 3'd0);

        // Clock loss in RUN
        base = cyc; enable = 1;
        goto(60); frame_start = 1;
        goto(61); frame_start = 0; chk3("cl_run", state, 3'd4);
        goto(65); pll_locked = 0;
        goto(66); pll_locked = 1;
        chk1("cl_fault", fault, 1'b1); chk3("cl_st", state, 3'd5);
        goto(136); chk3("cl_off", state, 3'd0);
        goto(145); chk3("cl_hold", state, 3'd0); chk1("cl_fault_hold", fault, 1'b1);
        enable = 0;
        goto(146); chk1("cl_fault_clr", fault, 1'b0); enable = 1;
        goto(147); chk3("cl_restart", state, 3'd1);

        // Reset mid-operation
        base = base + 146;
        goto(60); frame_start = 1;
        goto(61); frame_start = 0; chk3("rm_run", state, 3'd4);
        goto(70); rst = 1;
        goto(71);
        chk3("rm_st", state, 3'd0); chk1("rm_vdd", panel_vdd_en, 1'b0);
        chk1("rm_vid", video_en, 1'b0); chk1("rm_led", led_en, 1'b0);
        chk1("rm_pwm", led_pwm, 1'b0); chk1("rm_ready", ready, 1'b0);
        chk1("rm_fault", fault, 1'b0);
        rst = 0;
        goto(72); chk3("rm_restart", state, 3'd1);

        // Random phase
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            pll_locked  = ($urandom_range(0, 399) != 0);
            frame_start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: brightness = 8'd0;
                    1: brightness = 8'd255;
                    default: brightness = 8'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 4999) == 0);
        end
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
